// File: rtl/jt900h_pkg.sv
// jt900h_pkg: size encodings, address field positions, context FSM states and lane helpers
// shared by the banked register file and its context engine.
package jt900h_pkg;
   localparam logic [1:0] BYTE_SZ = 2'd0, WORD_SZ = 2'd1, LONG_SZ = 2'd2;
   localparam int LANE_LSB = 0, REG_LSB = 2, BANK_LSB = 4;
   typedef enum logic [2:0] {CTX_IDLE, CTX_REQ, CTX_WAIT, CTX_NEXT, CTX_DONE} ctx_st_t;
   function automatic logic [4:0] lane_sh(input logic [1:0] sz, input logic [1:0] lane);
      return sz >= LONG_SZ ? 5'd0 : sz == WORD_SZ ? {lane[1], 4'b0} : {lane, 3'b0};
   endfunction
   function automatic logic [31:0] rsel(input logic [31:0] v, input logic [1:0] sz, input logic [1:0] lane);
      logic [31:0] s;
      s = v >> lane_sh(sz, lane);
      return sz >= LONG_SZ ? s : sz == WORD_SZ ? {16'd0, s[15:0]} : {24'd0, s[7:0]};
   endfunction
   // unselected bytes of the old value survive through the mask
   function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] sz, input logic [1:0] lane);
      logic [31:0] m;
      m = (sz >= LONG_SZ ? 32'hFFFF_FFFF : sz == WORD_SZ ? 32'h0000_FFFF : 32'h0000_00FF) << lane_sh(sz, lane);
      return (old & ~m) | ((d << lane_sh(sz, lane)) & m);
   endfunction
endpackage

// File: rtl/jt900h_rbank_ctx.sv
// jt900h_rbank_ctx: context engine that saves or restores the four accumulators of one bank
// over a req/ack memory bus; restored words leave through a write port into the array.
module jt900h_rbank_ctx
   import jt900h_pkg::*;
#(
   parameter int BW = 2
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic          sv_start,
   input  logic          sv_dir,
   input  logic [BW-1:0] sv_bank,
   input  logic [23:0]   sv_base,
   input  logic [127:0]  bank_regs,
   output logic [BW-1:0] bank_sel,
   output logic          rs_we,
   output logic [1:0]    rs_idx,
   output logic [31:0]   rs_data,
   output logic          mem_req,
   output logic          mem_we,
   output logic [23:0]   mem_addr,
   output logic [31:0]   mem_dout,
   input  logic [31:0]   mem_din,
   input  logic          mem_ack,
   output logic          sv_busy,
   output logic          sv_done
);
   ctx_st_t st_q;
   logic dir_q;
   logic [BW-1:0] bank_q;
   logic [23:0] base_q;
   logic [1:0] i_q;
   // before latching, the array must already present the requested bank for word 0
   assign bank_sel = st_q == CTX_IDLE ? sv_bank : bank_q;
   assign rs_we = cen && st_q == CTX_WAIT && mem_ack && dir_q;
   assign rs_idx = i_q;
   assign rs_data = mem_din;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st_q <= CTX_IDLE;
         dir_q <= 1'b0;
         bank_q <= '0;
         base_q <= '0;
         i_q <= '0;
         mem_req <= 1'b0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_dout <= '0;
         sv_busy <= 1'b0;
         sv_done <= 1'b0;
      end else if (cen)
         case (st_q)
            CTX_IDLE: if (sv_start) begin
               st_q <= CTX_REQ;
               dir_q <= sv_dir;
               bank_q <= sv_bank;
               base_q <= sv_base;
               i_q <= '0;
               sv_busy <= 1'b1;
               mem_req <= 1'b1;
               mem_we <= ~sv_dir;
               mem_addr <= sv_base;
               mem_dout <= bank_regs[31:0];
            end
            CTX_REQ: st_q <= CTX_WAIT;
            CTX_WAIT: if (mem_ack) begin
               mem_req <= 1'b0;
               mem_we <= 1'b0;
               if (i_q == 2'd3) begin
                  st_q <= CTX_DONE;
                  sv_done <= 1'b1;
               end else begin
                  st_q <= CTX_NEXT;
                  i_q <= i_q + 2'd1;
               end
            end
            CTX_NEXT: begin
               st_q <= CTX_REQ;
               mem_req <= 1'b1;
               mem_we <= ~dir_q;
               mem_addr <= base_q + {20'd0, i_q, 2'b00};
               mem_dout <= bank_regs[{i_q, 5'd0} +: 32];
            end
            CTX_DONE: begin
               st_q <= CTX_IDLE;
               sv_done <= 1'b0;
               sv_busy <= 1'b0;
            end
            default: st_q <= CTX_IDLE;
         endcase
endmodule

// File: rtl/jt900h_rbank.sv
// jt900h_rbank: banked register file with two combinational read ports, one sized write port,
// shared pointer registers and a bank save/restore engine.
module jt900h_rbank
   import jt900h_pkg::*;
#(
   parameter int          NBANK  = 4,
   parameter int          NPTR   = 4,
   parameter logic [31:0] SP_RST = 32'h100,
   localparam int         BW     = $clog2(NBANK),
   localparam int         AW     = BW + 5
)(
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   output logic [BW-1:0] rfp,
   input  logic          rfp_we,
   input  logic [BW-1:0] rfp_din,
   input  logic [AW-1:0] ra0,
   input  logic [AW-1:0] ra1,
   input  logic [1:0]    rsz0,
   input  logic [1:0]    rsz1,
   output logic [31:0]   rd0,
   output logic [31:0]   rd1,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [1:0]    wsz,
   input  logic [31:0]   wd,
   input  logic          sv_start,
   input  logic          sv_dir,
   input  logic [BW-1:0] sv_bank,
   input  logic [23:0]   sv_base,
   output logic          mem_req,
   output logic          mem_we,
   output logic [23:0]   mem_addr,
   output logic [31:0]   mem_dout,
   input  logic [31:0]   mem_din,
   input  logic          mem_ack,
   output logic          sv_busy,
   output logic          sv_done
);
   localparam int PTR_BIT = BANK_LSB + BW;
   logic [31:0] accs_q [NBANK][4];
   logic [31:0] accs_d [NBANK][4];
   logic [31:0] ptrs_q [NPTR];
   logic [31:0] ptrs_d [NPTR];
   logic [BW-1:0] rfp_q, rfp_d, ctx_bank, wbank;
   logic [1:0] wreg, wlane, rs_idx;
   logic [127:0] ctx_regs;
   logic [31:0] rs_data, r0, r1;
   logic rs_we;
   assign rfp = rfp_q;
   assign wbank = wa[BANK_LSB +: BW];
   assign wreg = wa[REG_LSB +: 2];
   assign wlane = wa[LANE_LSB +: 2];
   assign r0 = ra0[PTR_BIT] ? ptrs_q[ra0[REG_LSB +: 2]] : accs_q[ra0[BANK_LSB +: BW]][ra0[REG_LSB +: 2]];
   assign r1 = ra1[PTR_BIT] ? ptrs_q[ra1[REG_LSB +: 2]] : accs_q[ra1[BANK_LSB +: BW]][ra1[REG_LSB +: 2]];
   assign rd0 = rsel(r0, rsz0, ra0[LANE_LSB +: 2]);
   assign rd1 = rsel(r1, rsz1, ra1[LANE_LSB +: 2]);
   assign ctx_regs = {accs_q[ctx_bank][3], accs_q[ctx_bank][2], accs_q[ctx_bank][1], accs_q[ctx_bank][0]};
   // core writes into the bank owned by the context engine are discarded until it finishes
   always_comb begin
      accs_d = accs_q;
      ptrs_d = ptrs_q;
      rfp_d = rfp_we ? rfp_din : rfp_q;
      if (we && wa[PTR_BIT])
         ptrs_d[wreg] = wmerge(ptrs_q[wreg], wd, wsz, wlane);
      if (we && !wa[PTR_BIT] && !(sv_busy && wbank == ctx_bank))
         accs_d[wbank][wreg] = wmerge(accs_q[wbank][wreg], wd, wsz, wlane);
      if (rs_we)
         accs_d[ctx_bank][rs_idx] = rs_data;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int b = 0; b < NBANK; b++)
            for (int r = 0; r < 4; r++)
               accs_q[b][r] <= '0;
         for (int p = 0; p < NPTR; p++)
            ptrs_q[p] <= p == NPTR - 1 ? SP_RST : '0;
         rfp_q <= '0;
      end else if (cen) begin
         accs_q <= accs_d;
         ptrs_q <= ptrs_d;
         rfp_q <= rfp_d;
      end
   jt900h_rbank_ctx #(.BW(BW)) u_ctx (
      .rst       (rst),
      .clk       (clk),
      .cen       (cen),
      .sv_start  (sv_start),
      .sv_dir    (sv_dir),
      .sv_bank   (sv_bank),
      .sv_base   (sv_base),
      .bank_regs (ctx_regs),
      .bank_sel  (ctx_bank),
      .rs_we     (rs_we),
      .rs_idx    (rs_idx),
      .rs_data   (rs_data),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_din   (mem_din),
      .mem_ack   (mem_ack),
      .sv_busy   (sv_busy),
      .sv_done   (sv_done)
   );
endmodule

// File: tb/tb_jt900h_rbank.sv
// tb_jt900h_rbank: randomized and directed bench checking the register file and context engine
// against a transaction-level model of banks, pointers and expected memory traffic.
module tb_jt900h_rbank;
   logic clk = 1'b0, rst, cen;
   logic [1:0] rfp;
   logic rfp_we, we, sv_start, sv_dir, mem_req, mem_we, mem_ack, sv_busy, sv_done;
   logic [1:0] rfp_din, rsz0, rsz1, wsz, sv_bank;
   logic [6:0] ra0, ra1, wa;
   logic [31:0] rd0, rd1, wd, mem_dout, mem_din;
   logic [23:0] sv_base, mem_addr;
   logic [2:0] rfp8, rfp_din8;
   logic rfp_we8, we8, m8_req, m8_we, m8_busy, m8_done;
   logic [7:0] ra0_8, ra1_8, wa8;
   logic [31:0] rd0_8, rd1_8, wd8, m8_dout;
   logic [23:0] m8_addr;
   typedef struct {logic [23:0] a; logic w; logic [31:0] d;} tx_t;
   tx_t q[$];
   logic [23:0] a_log[$];
   logic [31:0] d_log[$];
   logic [31:0] m_acc [4][4];
   logic [31:0] m_ptr [4];
   logic [1:0] m_rfp, l_bank;
   logic m_busy, m_done, l_dir, started;
   int checks = 0, errors = 0, rcnt = 0, rdly = 2, fix_dly = 0;

   always #5 clk = ~clk;

   jt900h_rbank dut (
      .rst(rst), .clk(clk), .cen(cen), .rfp(rfp), .rfp_we(rfp_we), .rfp_din(rfp_din),
      .ra0(ra0), .ra1(ra1), .rsz0(rsz0), .rsz1(rsz1), .rd0(rd0), .rd1(rd1),
      .we(we), .wa(wa), .wsz(wsz), .wd(wd),
      .sv_start(sv_start), .sv_dir(sv_dir), .sv_bank(sv_bank), .sv_base(sv_base),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
      .mem_din(mem_din), .mem_ack(mem_ack), .sv_busy(sv_busy), .sv_done(sv_done)
   );

   jt900h_rbank #(.NBANK(8)) dut8 (
      .rst(rst), .clk(clk), .cen(1'b1), .rfp(rfp8), .rfp_we(rfp_we8), .rfp_din(rfp_din8),
      .ra0(ra0_8), .ra1(ra1_8), .rsz0(2'd2), .rsz1(2'd2), .rd0(rd0_8), .rd1(rd1_8),
      .we(we8), .wa(wa8), .wsz(2'd2), .wd(wd8),
      .sv_start(1'b0), .sv_dir(1'b0), .sv_bank(3'd0), .sv_base(24'd0),
      .mem_req(m8_req), .mem_we(m8_we), .mem_addr(m8_addr), .mem_dout(m8_dout),
      .mem_din(32'd0), .mem_ack(1'b0), .sv_busy(m8_busy), .sv_done(m8_done)
   );

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 4; b++) begin
         for (int r = 0; r < 4; r++) m_acc[b][r] = 0;
         m_ptr[b] = 0;
      end
      m_ptr[3] = 32'h100;
      m_rfp = 0;
      m_busy = 0;
      m_done = 0;
      started = 0;
      q.delete();
   endtask

   function automatic logic [31:0] mread(input logic [6:0] a, input logic [1:0] sz);
      logic [31:0] v;
      v = a[6] ? m_ptr[a[3:2]] : m_acc[a[5:4]][a[3:2]];
      if (sz == 0) return (v >> (8 * a[1:0])) & 32'hFF;
      if (sz == 1) return (v >> (16 * a[1])) & 32'hFFFF;
      return v;
   endfunction

   task automatic mwrite(input logic bp);
      logic [31:0] v;
      int first;
      if (!wa[6] && bp && wa[5:4] == l_bank) return;
      v = wa[6] ? m_ptr[wa[3:2]] : m_acc[wa[5:4]][wa[3:2]];
      first = wsz >= 2 ? 0 : wsz == 1 ? 2 * wa[1] : int'(wa[1:0]);
      for (int b = 0; b < 4; b++)
         if (wsz >= 2 || (wsz == 1 && b / 2 == wa[1]) || (wsz == 0 && b == wa[1:0]))
            v[8*b +: 8] = wd[8*(b-first) +: 8];
      if (wa[6]) m_ptr[wa[3:2]] = v;
      else m_acc[wa[5:4]][wa[3:2]] = v;
   endtask

   task automatic model_edge(input logic c, input logic rp, input logic [31:0] dp,
                             input logic [23:0] ap, input logic [31:0] op);
      logic bp;
      bp = m_busy;
      started = 0;
      if (c) begin
         if (m_done) begin m_done = 0; m_busy = 0; end
         if (sv_start && !bp) begin
            m_busy = 1; l_dir = sv_dir; l_bank = sv_bank; started = 1;
            for (int k = 0; k < 4; k++)
               q.push_back(tx_t'{a: sv_base + 24'(4 * k), w: !sv_dir, d: m_acc[sv_bank][k]});
         end
         if (rfp_we) m_rfp = rfp_din;
         if (we) mwrite(bp);
      end
      // a falling request marks a completed transfer
      if (rp && !mem_req && q.size() > 0) begin
         if (l_dir) m_acc[l_bank][4 - q.size()] = dp;
         a_log.push_back(ap);
         d_log.push_back(l_dir ? dp : op);
         q.delete(0);
         if (q.size() == 0) m_done = 1;
      end
   endtask

   task automatic compare();
      chk("rd0", rd0, mread(ra0, rsz0));
      chk("rd1", rd1, mread(ra1, rsz1));
      chk("rfp", {30'd0, rfp}, {30'd0, m_rfp});
      chk("busy", {31'd0, sv_busy}, {31'd0, m_busy});
      chk("done", {31'd0, sv_done}, {31'd0, m_done});
      if (started) chk("req_rise", {31'd0, mem_req}, 32'd1);
      if (q.size() == 0) chk("req_idle", {31'd0, mem_req}, 32'd0);
      else if (mem_req) begin
         chk("addr", {8'd0, mem_addr}, {8'd0, q[0].a});
         chk("mwe", {31'd0, mem_we}, {31'd0, q[0].w});
         if (q[0].w) chk("dout", mem_dout, q[0].d);
      end
   endtask

   task automatic respond();
      if (!mem_req) begin mem_ack = 0; rcnt = 0; end
      else if (!mem_ack) begin
         rcnt++;
         if (rcnt >= rdly) begin
            mem_ack = 1;
            mem_din = $urandom;
            rdly = fix_dly != 0 ? fix_dly : $urandom_range(1, 4);
         end
      end
   endtask

   task automatic step();
      logic rp, c, r;
      logic [31:0] dp, op;
      logic [23:0] ap;
      rp = mem_req; dp = mem_din; ap = mem_addr; op = mem_dout; c = cen; r = rst;
      @(posedge clk);
      @(negedge clk);
      if (rst || r) model_reset();
      else model_edge(c, rp, dp, ap, op);
      compare();
      respond();
   endtask

   task automatic wait_idle(input string n);
      int k;
      k = 0;
      while (sv_busy && k < 200) begin step(); k++; end
      chk(n, {31'd0, sv_busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      logic [31:0] e;
      rst = 1; cen = 1; rfp_we = 0; rfp_din = 0; we = 0; wa = 0; wsz = 0; wd = 0;
      ra0 = 0; ra1 = 0; rsz0 = 0; rsz1 = 0; sv_start = 0; sv_dir = 0; sv_bank = 0; sv_base = 0;
      mem_ack = 0; mem_din = 0; rfp_we8 = 0; rfp_din8 = 0; we8 = 0; wa8 = 0; wd8 = 0; ra0_8 = 0; ra1_8 = 0;
      model_reset();
      step(); step();
      rst = 0;
      // reset contents: only the stack pointer is non-zero
      rsz0 = 2;
      for (int a = 0; a < 128; a++) begin
         ra0 = 7'(a);
         step();
         e = (ra0[6] && ra0[3:2] == 2'd3) ? 32'h100 : 32'h0;
         chk("t1_rd", rd0, e);
      end
      chk("t1_rfp", {30'd0, rfp}, 32'd0);
      we = 1; wa = {1'b0, 2'd1, 2'd2, 2'd0}; wsz = 2; wd = 32'h11223344; step();
      wa = {1'b0, 2'd1, 2'd2, 2'd3}; wsz = 0; wd = 32'h000000AA; step();
      we = 0; ra0 = {1'b0, 2'd1, 2'd2, 2'd0}; rsz0 = 2; ra1 = {1'b0, 2'd1, 2'd2, 2'd2}; rsz1 = 1; step();
      chk("t2_long", rd0, 32'hAA223344);
      chk("t2_word", rd1, 32'h0000AA22);
      // save bank 2 with a three-cycle acknowledge
      for (int k = 0; k < 4; k++) begin
         we = 1; wa = {1'b0, 2'd2, 2'(k), 2'd0}; wsz = 2; wd = 32'hB0B00000 | k; step();
      end
      we = 0; a_log.delete(); d_log.delete(); fix_dly = 3; rdly = 3;
      sv_start = 1; sv_dir = 0; sv_bank = 2; sv_base = 24'h1000; step();
      sv_start = 0; dones = 0;
      for (int k = 0; k < 200 && sv_busy; k++) begin step(); if (sv_done) dones++; end
      chk("t3_idle", {31'd0, sv_busy}, 32'd0);
      for (int k = 0; k < 3; k++) begin step(); if (sv_done) dones++; end
      chk("t3_dones", dones, 1);
      chk("t3_count", a_log.size(), 4);
      for (int k = 0; k < a_log.size() && k < 4; k++) begin
         chk("t3_addr", {8'd0, a_log[k]}, 32'h1000 + 4 * k);
         chk("t3_data", d_log[k], 32'hB0B00000 | k);
      end
      // restore bank 1 across the address wrap while the core writes banks 1 and 0
      a_log.delete(); d_log.delete(); fix_dly = 2; rdly = 2;
      sv_start = 1; sv_dir = 1; sv_bank = 1; sv_base = 24'hFFFFF8; step();
      sv_start = 0;
      for (int k = 0; k < 50 && a_log.size() == 0; k++) step();
      we = 1; wa = {1'b0, 2'd1, 2'd0, 2'd0}; wsz = 2; wd = 32'hDEADBEEF; step();
      wa = {1'b0, 2'd0, 2'd0, 2'd0}; wd = 32'h5A5A5A5A; step();
      we = 0;
      wait_idle("t4_idle");
      chk("t4_count", a_log.size(), 4);
      if (a_log.size() == 4) begin
         chk("t4_a0", {8'd0, a_log[0]}, 32'hFFFFF8);
         chk("t4_a1", {8'd0, a_log[1]}, 32'hFFFFFC);
         chk("t4_a2", {8'd0, a_log[2]}, 32'h000000);
         chk("t4_a3", {8'd0, a_log[3]}, 32'h000004);
      end
      ra0 = {1'b0, 2'd0, 2'd0, 2'd0}; rsz0 = 2; ra1 = {1'b0, 2'd1, 2'd0, 2'd0}; rsz1 = 2; step();
      chk("t4_bank0", rd0, 32'h5A5A5A5A);
      if (d_log.size() > 0) chk("t4_bank1", rd1, d_log[0]);
      // reset in the middle of a slow transfer, with a second start ignored
      fix_dly = 20; rdly = 20;
      sv_start = 1; sv_dir = 1; sv_bank = 3; sv_base = 24'h2000; step();
      sv_bank = 0; sv_base = 24'h3000; step();
      sv_start = 0; step();
      chk("t5_addr", {8'd0, mem_addr}, 32'h2000);
      chk("t5_req", {31'd0, mem_req}, 32'd1);
      #2 rst = 1;
      #1 chk("t5_rst_req", {31'd0, mem_req}, 32'd0);
      chk("t5_rst_busy", {31'd0, sv_busy}, 32'd0);
      step(); step();
      rst = 0; fix_dly = 0; rdly = 2; step();
      // eight-bank build keeps bank 7 apart from bank 3
      rfp_we8 = 1; rfp_din8 = 7; we8 = 1; wa8 = {1'b0, 3'd7, 2'd0, 2'd0}; wd8 = 32'hCAFE0007; step();
      rfp_we8 = 0; wa8 = {1'b0, 3'd3, 2'd0, 2'd0}; wd8 = 32'h33333333; step();
      we8 = 0; ra0_8 = {1'b0, 3'd7, 2'd0, 2'd0}; ra1_8 = {1'b0, 3'd3, 2'd0, 2'd0}; step();
      chk("t6_bank7", rd0_8, 32'hCAFE0007);
      chk("t6_bank3", rd1_8, 32'h33333333);
      chk("t6_rfp", {29'd0, rfp8}, 32'd7);
      for (int n = 0; n < 4000; n++) begin
         cen = $urandom_range(0, 7) != 0;
         we = 1'($urandom); wa = 7'($urandom); wsz = 2'($urandom); wd = $urandom;
         rfp_we = $urandom_range(0, 9) == 0; rfp_din = 2'($urandom);
         ra0 = 7'($urandom); ra1 = 7'($urandom); rsz0 = 2'($urandom); rsz1 = 2'($urandom);
         sv_start = $urandom_range(0, 19) == 0; sv_dir = 1'($urandom); sv_bank = 2'($urandom);
         sv_base = $urandom_range(0, 1) != 0 ? 24'hFFFFF0 + 24'($urandom_range(0, 15)) : 24'($urandom);
         if (sv_start) we = 0;
         step();
      end
      cen = 1; sv_start = 0; we = 0;
      wait_idle("final_idle");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
